hazard_stall_controller: RTL and testbench

- Pipeline sequencing controller for the 5-stage MIPS core; sits alongside the forwarding logic.
- Decides when PC and IF/ID freeze, when a bubble is injected into ID/EX, and when IF/ID is flushed.
- Owns the multi-cycle multiply/divide unit: issues starts, tracks busy time, stalls dependent instructions.
- Covers hazards that forwarding cannot resolve: load-use, branch-in-ID operand not ready, HI/LO busy.

---
 rtl/hazard_stall_controller.sv | 122 ++++++++++++
 tb/tb_hazard_stall_controller.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller for the 5-stage MIPS core.
// Detects hazards that forwarding cannot cover (load-use, branch operand
// not ready in ID, HI/LO still being produced), freezes PC and IF/ID,
// injects ID/EX bubbles, flushes IF/ID on redirects, and owns the
// multi-cycle multiply/divide unit's start/busy/done sequencing.
module hazard_stall_controller #(
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 32,
   parameter int CNT_W   = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rs,
   input  logic        id_uses_rt,
   input  logic        id_is_branch,
   input  logic        id_is_muldiv,
   input  logic        id_is_div,
   input  logic        id_uses_hilo,
   input  logic        ex_reg_write,
   input  logic        ex_mem_read,
   input  logic [4:0]  ex_rd,
   input  logic        mem_mem_read,
   input  logic [4:0]  mem_rd,
   input  logic        redirect,
   output logic        pc_write,
   output logic        if_id_write,
   output logic        if_id_flush,
   output logic        id_ex_bubble,
   output logic        md_start,
   output logic        md_busy,
   output logic        md_done,
   output logic [31:0] stall_count
);

   typedef enum logic {IDLE, BUSY} state_t;

   // Busy-counter reload values: the unit stays BUSY for exactly LAT cycles.
   localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_LAT - 1);

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             md_done_nx;
   logic             ex_match, mem_match;
   logic             load_use, br_haz, md_haz, stall;

   // Operand-match and hazard classification for the instruction in ID.
   always_comb begin
      // NOTE: every signal assigned in a combinational block gets a default
      // first so no path leaves it unassigned and a latch is never inferred.
      ex_match  = 1'b0;
      mem_match = 1'b0;
      if (ex_rd != 5'd0)
         ex_match = (id_uses_rs && (ex_rd == id_rs)) ||
                    (id_uses_rt && (ex_rd == id_rt));
      if (mem_rd != 5'd0)
         mem_match = (id_uses_rs && (mem_rd == id_rs)) ||
                     (id_uses_rt && (mem_rd == id_rt));
      load_use = ex_mem_read && ex_match;
      br_haz   = id_is_branch &&
                 ((ex_reg_write && ex_match) || (mem_mem_read && mem_match));
      md_haz   = (id_is_muldiv || id_uses_hilo) && (state == BUSY);
      stall    = load_use || br_haz || md_haz;
   end

   // Pipeline control outputs; a stall overrides any redirect flush.
   always_comb begin
      pc_write     = !stall;
      if_id_write  = !stall;
      id_ex_bubble = stall;
      if_id_flush  = redirect && !stall;
      md_start     = id_is_muldiv && !stall;
      md_busy      = (state == BUSY);
   end

   // Mul/div FSM next state, busy down-counter and done pulse.
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      md_done_nx = 1'b0;
      case (state)
         IDLE: begin
            if (md_start) begin
               state_nx = BUSY;
               cnt_nx   = id_is_div ? DIV_INIT : MUL_INIT;
            end
         end
         BUSY: begin
            if (cnt != '0) begin
               cnt_nx = cnt - 1'b1;
            end else begin
               state_nx   = IDLE;
               md_done_nx = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // State register, done pulse and saturating stall counter.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: every control register is cleared by reset so an abandoned
      // mul/div op can never raise md_done after reset is released.
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         md_done     <= 1'b0;
         stall_count <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all
         // registers update together from pre-edge values.
         state   <= state_nx;
         cnt     <= cnt_nx;
         md_done <= md_done_nx;
         if (stall && (stall_count != 32'hFFFF_FFFF))
            stall_count <= stall_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed testbench for hazard_stall_controller (MUL_LAT=4, DIV_LAT=32).
module tb_hazard_stall_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  id_rs, id_rt, ex_rd, mem_rd;
   logic        id_uses_rs, id_uses_rt, id_is_branch, id_is_muldiv, id_is_div;
   logic        id_uses_hilo, ex_reg_write, ex_mem_read, mem_mem_read, redirect;
   logic        pc_write, if_id_write, if_id_flush, id_ex_bubble;
   logic        md_start, md_busy, md_done;
   logic [31:0] stall_count;

   int n_checks = 0;
   int n_pass   = 0;

   hazard_stall_controller #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(6)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_is_branch(id_is_branch), .id_is_muldiv(id_is_muldiv),
      .id_is_div(id_is_div), .id_uses_hilo(id_uses_hilo),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
      .mem_mem_read(mem_mem_read), .mem_rd(mem_rd), .redirect(redirect),
      .pc_write(pc_write), .if_id_write(if_id_write),
      .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
      .md_start(md_start), .md_busy(md_busy), .md_done(md_done),
      .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic clr();
      id_rs = '0; id_rt = '0; ex_rd = '0; mem_rd = '0;
      id_uses_rs = 0; id_uses_rt = 0; id_is_branch = 0; id_is_muldiv = 0;
      id_is_div = 0; id_uses_hilo = 0; ex_reg_write = 0; ex_mem_read = 0;
      mem_mem_read = 0; redirect = 0;
   endtask

   // Advance one clock; inputs change and outputs are sampled 2ns later.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   int busy_n, stall_n, done_n, k;

   initial begin
      clr();
      rst_n = 1'b0;
      #1;
      check("rst_pc_write", 32'(pc_write), 1);
      check("rst_bubble", 32'(id_ex_bubble), 0);
      check("rst_busy", 32'(md_busy), 0);
      check("rst_done", 32'(md_done), 0);
      check("rst_stall_count", stall_count, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Load-use through rs: one-cycle stall.
      ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd8;
      id_uses_rs = 1; id_rs = 5'd8;
      #1;
      check("lu_pc_write", 32'(pc_write), 0);
      check("lu_if_id_write", 32'(if_id_write), 0);
      check("lu_bubble", 32'(id_ex_bubble), 1);
      tick();
      check("lu_count", stall_count, 1);
      // Load now in MEM, bubble in EX: a non-branch consumer proceeds.
      ex_mem_read = 0; ex_reg_write = 0; mem_mem_read = 1; mem_rd = 5'd8;
      #1;
      check("lu_next_pc_write", 32'(pc_write), 1);
      tick();
      check("lu_next_count", stall_count, 1);

      // Load-use through rt; rt ignored when not used; $zero never matches.
      clr();
      ex_mem_read = 1; ex_rd = 5'd12; id_rt = 5'd12; id_uses_rt = 0;
      #1;
      check("rt_unused", 32'(id_ex_bubble), 0);
      id_uses_rt = 1;
      #1;
      check("rt_lu", 32'(id_ex_bubble), 1);
      tick();
      clr();
      ex_mem_read = 1; ex_rd = 5'd0; id_rs = 5'd0; id_uses_rs = 1;
      #1;
      check("lu_r0", 32'(id_ex_bubble), 0);
      tick();
      check("rt_count", stall_count, 2);

      // Branch in ID: ALU producer in EX, then load producer in MEM.
      clr();
      id_is_branch = 1; id_uses_rs = 1; id_rs = 5'd9;
      ex_reg_write = 1; ex_rd = 5'd9;
      #1;
      check("br_ex", 32'(pc_write), 0);
      tick();
      ex_reg_write = 0; ex_rd = 5'd0; mem_mem_read = 1; mem_rd = 5'd9;
      #1;
      check("br_mem", 32'(id_ex_bubble), 1);
      tick();
      ex_reg_write = 1; ex_rd = 5'd0; mem_rd = 5'd0; id_rs = 5'd0;
      #1;
      check("br_r0", 32'(id_ex_bubble), 0);
      tick();
      check("br_count", stall_count, 4);

      // Divide, then mflo three cycles later.
      clr();
      id_is_muldiv = 1; id_is_div = 1;
      #1;
      check("div_start", 32'(md_start), 1);
      tick();
      clr();
      check("div_start_once", 32'(md_start), 0);
      busy_n = 0; stall_n = 0; done_n = 0; k = 0;
      while (md_busy && k < 100) begin
         id_uses_hilo = (k >= 2);
         #1;
         busy_n++;
         if (id_ex_bubble) stall_n++;
         if (md_done) done_n++;
         tick();
         k++;
      end
      #1;
      check("div_busy_cycles", busy_n, 32);
      check("div_mflo_stalls", stall_n, 30);
      check("div_done_early", done_n, 0);
      check("div_done", 32'(md_done), 1);
      check("div_mflo_issue", 32'(pc_write), 1);
      tick();
      clr();
      check("div_done_pulse", 32'(md_done), 0);
      check("div_count", stall_count, 34);

      // Multiply followed by independent adds.
      id_is_muldiv = 1; id_is_div = 0;
      #1;
      check("mul_start", 32'(md_start), 1);
      tick();
      clr();
      k = 1; stall_n = 0;
      while (!md_done && k < 20) begin
         id_uses_rs = 1; id_rs = 5'(k + 4);
         #1;
         if (id_ex_bubble || md_start) stall_n++;
         tick();
         k++;
      end
      check("mul_done_cycle", k, 5);
      check("mul_no_stall", stall_n, 0);
      check("mul_count", stall_count, 34);

      // Redirect while stalled is ignored, then honoured.
      clr();
      redirect = 1; ex_mem_read = 1; ex_rd = 5'd3; id_uses_rs = 1; id_rs = 5'd3;
      #1;
      check("redir_stall_flush", 32'(if_id_flush), 0);
      check("redir_stall_bubble", 32'(id_ex_bubble), 1);
      tick();
      ex_mem_read = 0;
      #1;
      check("redir_flush", 32'(if_id_flush), 1);
      tick();
      clr();
      check("redir_count", stall_count, 35);

      // Reset in the middle of a divide (cnt = 10).
      id_is_muldiv = 1; id_is_div = 1;
      tick();
      clr();
      repeat (21) tick();
      check("mid_div_busy", 32'(md_busy), 1);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_mid_busy", 32'(md_busy), 0);
      check("rst_mid_count", stall_count, 0);
      tick();
      rst_n = 1'b1;
      done_n = 0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (md_done || md_busy) done_n++;
         tick();
      end
      check("rst_no_done", done_n, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
